// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if: serial link between the scan controller (master) and the ADC (slave).
interface adc_scan_ctrl_if;
    logic adc_cs_n;
    logic adc_sck;
    logic din;
    logic dout;
    modport master (output adc_cs_n, adc_sck, din, input dout);
    modport slave (input adc_cs_n, adc_sck, din, output dout);
endinterface

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans ADC channels 5/6/7 and derives a 3-bit line pattern; define ADC_HYST_EN for hysteretic pattern bits.
module adc_scan_ctrl #(
    parameter int SCK_DIV = 2,
    parameter int HYST = 16
) (
    input  logic clk_50,
    input  logic rst,
    input  logic scan_en,
    input  logic [11:0] thr,
    adc_scan_ctrl_if.master adc,
    output logic [11:0] d_out_ch5,
    output logic [11:0] d_out_ch6,
    output logic [11:0] d_out_ch7,
    output logic [2:0] pattern,
    output logic sample_valid,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic ph, ph_n;
    logic [3:0] k, k_n;
    logic [10:0] shreg;
    logic [1:0] ch, prev;
    logic disc;
    logic tick, sample, last, wr;
    logic cs_n_n, sck_n, din_n;
    logic [2:0] add;
    logic [11:0] res;
`ifdef ADC_HYST_EN
    localparam bit HYS_ON = 1'b1;
`else
    localparam bit HYS_ON = 1'b0;
`endif
    localparam logic [12:0] HB = HYS_ON ? 13'(HYST) : 13'd0;
    logic [12:0] thr_sum, thr_hi, thr_lo;
    assign thr_sum = {1'b0, thr} + HB;
    assign thr_hi = thr_sum > 13'd4095 ? 13'd4095 : thr_sum;
    assign thr_lo = {1'b0, thr} < HB ? 13'd0 : {1'b0, thr} - HB;
    function automatic logic pbit(input logic [11:0] v, input logic old, input logic [12:0] hi, input logic [12:0] lo);
        return {1'b0, v} > hi || (HYS_ON && {1'b0, v} >= lo && old);
    endfunction
    assign tick = cnt == 8'(SCK_DIV - 1);
    assign sample = state == SHIFT && ph && tick;
    assign last = sample && k == 4'd15;
    assign wr = last && !disc;
    assign res = {shreg, adc.dout};
    assign add = 3'd5 + {1'b0, ch};
    always_comb begin
        state_n = state;
        cnt_n = tick ? 8'd0 : cnt + 8'd1;
        ph_n = ph;
        k_n = k;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                state_n = scan_en ? SETUP : IDLE;
            end
            SETUP: begin
                ph_n = 1'b0;
                k_n = 4'd0;
                state_n = tick ? SHIFT : SETUP;
            end
            SHIFT: if (tick) begin
                ph_n = !ph;
                k_n = ph ? k + 4'd1 : k;
                state_n = ph && k == 4'd15 ? HOLD : SHIFT;
            end
            default: state_n = !tick ? HOLD : scan_en ? SETUP : IDLE;
        endcase
        // pins are registered from the next-state view so they change glitch-free with the state
        cs_n_n = !(state_n == SETUP || state_n == SHIFT);
        sck_n = !(state_n == SHIFT && !ph_n);
        din_n = state_n != SHIFT ? 1'b0 : k_n == 4'd2 ? add[2] : k_n == 4'd3 ? add[1] : k_n == 4'd4 ? add[0] : 1'b0;
    end
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            ph <= 1'b0;
            k <= '0;
            shreg <= '0;
            ch <= '0;
            prev <= '0;
            disc <= 1'b1;
            adc.adc_cs_n <= 1'b1;
            adc.adc_sck <= 1'b1;
            adc.din <= 1'b0;
            d_out_ch5 <= '0;
            d_out_ch6 <= '0;
            d_out_ch7 <= '0;
            pattern <= '0;
            sample_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ph <= ph_n;
            k <= k_n;
            adc.adc_cs_n <= cs_n_n;
            adc.adc_sck <= sck_n;
            adc.din <= din_n;
            busy <= state_n != IDLE;
            if (sample) shreg <= res[10:0];
            if (state == IDLE && scan_en) begin
                ch <= '0;
                disc <= 1'b1;
            end
            // the ADC returns the channel addressed one frame earlier
            if (last) begin
                ch <= ch == 2'd2 ? 2'd0 : ch + 2'd1;
                prev <= ch;
                disc <= 1'b0;
            end
            if (wr && prev == 2'd0) d_out_ch5 <= res;
            if (wr && prev == 2'd1) d_out_ch6 <= res;
            if (wr && prev == 2'd2) d_out_ch7 <= res;
            if (wr && prev == 2'd2)
                pattern <= {pbit(d_out_ch5, pattern[2], thr_hi, thr_lo), pbit(d_out_ch6, pattern[1], thr_hi, thr_lo), pbit(res, pattern[0], thr_hi, thr_lo)};
            sample_valid <= wr && prev == 2'd2;
        end
    end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: two controllers (SCK_DIV 2 and 1) against a behavioural ADC and a frame-level scoreboard.
module tb_adc_scan_ctrl;
    logic clk_50 = 1'b0, rst = 1'b1, scan_en = 1'b0;
    logic [11:0] thr = 12'h800;
    logic [1:0] cs, sck, din, sv, busy;
    logic [1:0] dout = 2'b00;
    logic [1:0][11:0] q5, q6, q7;
    logic [1:0][2:0] pat;
    int n_tests = 0, n_fail = 0;
`ifdef ADC_HYST_EN
    localparam int HB = 16;
    logic [3:0] exp35 = 4'b0110;
`else
    localparam int HB = 0;
    logic [3:0] exp35 = 4'b1100;
`endif
    adc_scan_ctrl_if a0 ();
    adc_scan_ctrl_if a1 ();
    assign cs = {a1.adc_cs_n, a0.adc_cs_n};
    assign sck = {a1.adc_sck, a0.adc_sck};
    assign din = {a1.din, a0.din};
    assign a0.dout = dout[0];
    assign a1.dout = dout[1];
    adc_scan_ctrl u0 (.clk_50(clk_50), .rst(rst), .scan_en(scan_en), .thr(thr), .adc(a0.master),
        .d_out_ch5(q5[0]), .d_out_ch6(q6[0]), .d_out_ch7(q7[0]), .pattern(pat[0]), .sample_valid(sv[0]), .busy(busy[0]));
    adc_scan_ctrl #(.SCK_DIV(1)) u1 (.clk_50(clk_50), .rst(rst), .scan_en(scan_en), .thr(thr), .adc(a1.master),
        .d_out_ch5(q5[1]), .d_out_ch6(q6[1]), .d_out_ch7(q7[1]), .pattern(pat[1]), .sample_valid(sv[1]), .busy(busy[1]));
    always #10 clk_50 = ~clk_50;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [2:0] pat_model(input logic [2:0] old, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        logic [2:0] r;
        int v, hi, lo;
        hi = int'(t) + HB > 4095 ? 4095 : int'(t) + HB;
        lo = int'(t) - HB < 0 ? 0 : int'(t) - HB;
        for (int j = 0; j < 3; j++) begin
            v = j == 0 ? int'(a) : j == 1 ? int'(b) : int'(c);
            r[2-j] = v > hi ? 1'b1 : (v < lo || HB == 0) ? 1'b0 : old[2-j];
        end
        return r;
    endfunction
    logic [11:0] val [8];
    logic [11:0] thr_s;
    logic rst_s;
    always @(posedge clk_50) begin
        thr_s = thr;
        rst_s = rst;
    end
    logic [1:0] pcs = 2'b11, psck = 2'b11, pdin = 2'b00, bad = 2'b00;
    int k [2], gap [2] = '{100, 100}, fidx [2], cyc [2], ft [2], lowc [2], svn [2];
    logic [2:0] addr [2], laddr [2] = '{3'd5, 3'd5};
    logic [11:0] data [2];
    logic [11:0] ex [2][3];
    logic [2:0] pm [2];
    bit got_sv [2];
    always @(negedge clk_50) begin
        for (int i = 0; i < 2; i++) begin
            int s, ch;
            logic exp_sv;
            s = i == 0 ? 2 : 1;
            exp_sv = 1'b0;
            if (rst_s) begin
                for (int j = 0; j < 3; j++) ex[i][j] = '0;
                pm[i] = '0;
            end
            cyc[i]++;
            if (!cs[i] && !sck[i]) lowc[i]++;
            if (din[i] !== pdin[i] && !(psck[i] && !sck[i])) bad[i] = 1'b1;
            if (cs[i] && !sck[i]) bad[i] = 1'b1;
            if (pcs[i] && !cs[i]) begin
                fidx[i] = gap[i] == s - 1 ? fidx[i] + 1 : 0;
                if (fidx[i] == 0) begin
                    cyc[i] = 0;
                    got_sv[i] = 1'b0;
                end
                ft[i] = cyc[i];
                k[i] = -1;
                addr[i] = '0;
                lowc[i] = 0;
                data[i] = val[laddr[i]];
            end
            if (!cs[i] && psck[i] && !sck[i]) begin
                k[i]++;
                if (k[i] >= 2 && k[i] <= 4) addr[i] = {addr[i][1:0], din[i]};
                dout[i] = k[i] >= 4 ? data[i][15-k[i]] : 1'b0;
            end
            if (din[i] && !(!cs[i] && k[i] >= 2 && k[i] <= 4)) bad[i] = 1'b1;
            if (!pcs[i] && cs[i]) begin
                gap[i] = 0;
                dout[i] = 1'b0;
                if (!rst_s) begin
                    check($sformatf("addr%0d", i), 32'(addr[i]), 32'(5 + fidx[i] % 3));
                    check($sformatf("din_proto%0d", i), 32'(bad[i]), 0);
                    check($sformatf("sck_low%0d", i), lowc[i], 16 * s);
                    check($sformatf("cs_len%0d", i), cyc[i] - ft[i], 33 * s);
                    laddr[i] = addr[i];
                    if (fidx[i] > 0) begin
                        ch = (fidx[i] - 1) % 3;
                        ex[i][ch] = data[i];
                        if (ch == 2) begin
                            pm[i] = pat_model(pm[i], ex[i][0], ex[i][1], ex[i][2], thr_s);
                            exp_sv = 1'b1;
                            svn[i]++;
                            if (!got_sv[i]) check($sformatf("first_sv%0d", i), cyc[i], 4 * 34 * s - s);
                            got_sv[i] = 1'b1;
                        end
                    end
                end
                bad[i] = 1'b0;
            end else if (cs[i]) gap[i]++;
            check($sformatf("sv%0d", i), 32'(sv[i]), 32'(exp_sv));
            check($sformatf("ch5_%0d", i), 32'(q5[i]), 32'(ex[i][0]));
            check($sformatf("ch6_%0d", i), 32'(q6[i]), 32'(ex[i][1]));
            check($sformatf("ch7_%0d", i), 32'(q7[i]), 32'(ex[i][2]));
            check($sformatf("pattern%0d", i), 32'(pat[i]), 32'(pm[i]));
            if (!cs[i]) check($sformatf("busy_cs%0d", i), 32'(busy[i]), 1);
            pcs[i] = cs[i];
            psck[i] = sck[i];
            pdin[i] = din[i];
        end
    end
    task automatic cycles(input int n);
        repeat (n) @(posedge clk_50);
        #2;
    endtask
    task automatic idle_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_cs%0d", tag, i), 32'(cs[i]), 1);
            check($sformatf("%s_sck%0d", tag, i), 32'(sck[i]), 1);
            check($sformatf("%s_din%0d", tag, i), 32'(din[i]), 0);
            check($sformatf("%s_out%0d", tag, i), {q5[i], q6[i], pat[i], sv[i], busy[i]}, 0);
            check($sformatf("%s_ch7_%0d", tag, i), 32'(q7[i]), 0);
        end
    endtask
    initial begin
        int sv0;
        logic [11:0] seq [4];
        seq = '{12'h40F, 12'h411, 12'h3F5, 12'h3EF};
        for (int j = 0; j < 8; j++) val[j] = '0;
        val[5] = 12'h123;
        val[6] = 12'h456;
        val[7] = 12'hABC;
        cycles(3);
        idle_zero("reset");
        rst = 1'b0;
        scan_en = 1'b1;
        cycles(4 * 68 + 4);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("base_ch5_%0d", i), 32'(q5[i]), 32'h123);
            check($sformatf("base_ch6_%0d", i), 32'(q6[i]), 32'h456);
            check($sformatf("base_ch7_%0d", i), 32'(q7[i]), 32'hABC);
            check($sformatf("base_pat%0d", i), 32'(pat[i]), 32'b001);
        end
        check("base_svn0", svn[0], 1);
        check("base_svn1", svn[1], 2);
        repeat (25) begin
            for (int j = 5; j < 8; j++) val[j] = 12'($urandom_range(0, 4095));
            thr = 12'($urandom_range(0, 4095));
            scan_en = $urandom_range(0, 3) != 0;
            cycles($urandom_range(1, 300));
        end
        scan_en = 1'b0;
        cycles(100);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("idle_busy%0d", i), 32'(busy[i]), 0);
            check($sformatf("idle_cs%0d", i), 32'(cs[i]), 1);
        end
        for (int j = 5; j < 8; j++) val[j] = 12'($urandom_range(0, 4095));
        sv0 = svn[0];
        scan_en = 1'b1;
        cycles(170);
        scan_en = 1'b0;
        cycles(100);
        check("drop_ch6", 32'(q6[0]), 32'(val[6]));
        check("drop_cs", 32'(cs[0]), 1);
        check("drop_busy", 32'(busy[0]), 0);
        check("drop_nosv", svn[0], sv0);
        scan_en = 1'b1;
        cycles(3 * 68 + 2 + 40);
        rst = 1'b1;
        cycles(1);
        idle_zero("abort");
        cycles(2);
        rst = 1'b0;
        cycles(5 * 68);
        check("restart_ch7", 32'(q7[0]), 32'(val[7]));
        scan_en = 1'b0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        thr = 12'h400;
        val[5] = '0;
        val[7] = '0;
        for (int j = 0; j < 4; j++) begin
            val[6] = seq[j];
            scan_en = 1'b1;
            cycles(250);
            scan_en = 1'b0;
            cycles(150);
            for (int i = 0; i < 2; i++) check($sformatf("hyst%0d_%0d", j, i), 32'(pat[i][1]), 32'(exp35[3-j]));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
